aes256_round_key_scheduler: RTL

//  Sequences the AES-256 key expander and caches its 15 round keys for the cipher core.

---
 rtl/aes256_round_key_scheduler.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/aes256_round_key_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : aes256_round_key_scheduler
//  Brief    : Loads an AES-256 cipher key, sequences the external key
//             expander, caches the 15 round keys and serves them by index
//             with a fixed one-cycle read latency.
//  Revision : 1.0  initial release
// ============================================================================
module aes256_round_key_scheduler #(
   parameter int KEY_W  = 256,
   parameter int RK_W   = 128,
   parameter int NUM_RK = 15
) (
   input  logic              clk,
   input  logic              reset,
   // cipher key load
   input  logic [KEY_W-1:0]  i_key_in,
   input  logic              i_key_valid,
   output logic              o_key_ready,
   input  logic              i_core_busy,
   // key expander interface
   output logic              o_kx_start,
   output logic [KEY_W-1:0]  o_kx_key,
   input  logic [RK_W-1:0]   i_kx_subkey,
   // round-key read port
   input  logic              i_rk_req,
   input  logic [3:0]        i_rk_idx,
   output logic              o_rk_valid,
   output logic [RK_W-1:0]   o_rk_data,
   output logic              o_rk_err,
   output logic              o_keys_valid
);

   localparam logic [3:0] c_LAST_IDX = 4'(NUM_RK - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_KX0     = 3'd1,
      S_KX1     = 3'd2,
      S_COLLECT = 3'd3,
      S_READY   = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [3:0]        r_cnt;
   logic [KEY_W-1:0]  r_kx_key;
   logic              r_keys_valid;
   logic [RK_W-1:0]   r_slot [NUM_RK];
   logic              r_rk_valid;
   logic [RK_W-1:0]   r_rk_data;
   logic              r_rk_err;

   logic              w_key_ready;
   logic              w_accept;
   logic              w_kx_start;
   logic              w_wr_en;
   logic [3:0]        w_wr_idx;
   logic              w_rd_ok;
   logic [RK_W-1:0]   w_rd_data;

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next state, handshake, expander start and slot write selection
   always_comb begin
      w_state_nxt = r_state;
      w_kx_start  = 1'b0;
      w_wr_en     = 1'b0;
      w_wr_idx    = 4'd0;
      // key_ready is low while reset is held so nothing is offered mid-reset
      w_key_ready = !reset && !i_core_busy &&
                    (r_state == S_IDLE || r_state == S_READY);
      w_accept    = w_key_ready && i_key_valid;
      case (r_state)
         S_IDLE, S_READY: begin
            if (w_accept) w_state_nxt = S_KX0;
         end
         // the expander needs start during both of its first two steps
         S_KX0: begin
            w_kx_start  = 1'b1;
            w_wr_en     = 1'b1;
            w_wr_idx    = 4'd0;
            w_state_nxt = S_KX1;
         end
         S_KX1: begin
            w_kx_start  = 1'b1;
            w_wr_en     = 1'b1;
            w_wr_idx    = 4'd1;
            w_state_nxt = S_COLLECT;
         end
         S_COLLECT: begin
            w_wr_en  = 1'b1;
            w_wr_idx = r_cnt;
            if (r_cnt == c_LAST_IDX) w_state_nxt = S_READY;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Key latch, collection counter and the keys-valid flag
   always_ff @(posedge clk) begin
      if (reset) begin
         r_kx_key     <= '0;
         r_keys_valid <= 1'b0;
         r_cnt        <= 4'd0;
      end else begin
         if (w_accept) begin
            r_kx_key     <= i_key_in;
            r_keys_valid <= 1'b0;
         end
         if (r_state == S_KX1) r_cnt <= 4'd2;
         if (r_state == S_COLLECT) begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == c_LAST_IDX) r_keys_valid <= 1'b1;
         end
      end
   end

   // Round-key register file, one slot captured per expansion cycle
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_RK; i++) begin
         if (reset)
            r_slot[i] <= '0;
         else if (w_wr_en && (w_wr_idx == 4'(i)))
            r_slot[i] <= i_kx_subkey;
      end
   end

   // Read mux: out-of-range index or an incomplete schedule yields zero
   always_comb begin
      w_rd_data = '0;
      w_rd_ok   = r_keys_valid && (i_rk_idx <= c_LAST_IDX);
      for (int i = 0; i < NUM_RK; i++) begin
         if (w_rd_ok && (i_rk_idx == 4'(i))) w_rd_data = r_slot[i];
      end
   end

   // Registered read response, one cycle after each request
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rk_valid <= 1'b0;
         r_rk_data  <= '0;
         r_rk_err   <= 1'b0;
      end else begin
         r_rk_valid <= i_rk_req;
         r_rk_data  <= i_rk_req ? w_rd_data : '0;
         r_rk_err   <= i_rk_req && !w_rd_ok;
      end
   end

   assign o_key_ready  = w_key_ready;
   assign o_kx_start   = w_kx_start;
   assign o_kx_key     = r_kx_key;
   assign o_keys_valid = r_keys_valid;
   assign o_rk_valid   = r_rk_valid;
   assign o_rk_data    = r_rk_data;
   assign o_rk_err     = r_rk_err;

endmodule
`default_nettype wire
